// File: rtl/aes_dec_round_sequencer_if.sv
// Handshake and datapath bundle between the AES decryption round sequencer
// and its environment (request source, round datapaths, plaintext consumer).
interface aes_dec_round_sequencer_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        key_len;
  logic [DATA_W-1:0] dec_in;
  logic [CNT_W-1:0]  dec_counter;
  logic [DATA_W-1:0] dec_out_128;
  logic [DATA_W-1:0] dec_out_192;
  logic [DATA_W-1:0] dec_out_256;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              err;

  // Environment side: request source, round datapaths and consumer.
  modport master (
    output in_valid, in_data, key_len, dec_out_128, dec_out_192, dec_out_256, out_ready,
    input  in_ready, dec_in, dec_counter, out_valid, out_data, busy, err
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, key_len, dec_out_128, dec_out_192, dec_out_256, out_ready,
    output in_ready, dec_in, dec_counter, out_valid, out_data, busy, err
  );
endinterface

// File: rtl/aes_dec_round_sequencer.sv
// Control sequencer for the iterative AES decryption round datapaths.
// Optional abort input enabled by defining AES_DEC_ABORT_EN.
module aes_dec_round_sequencer #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 6
) (
  input logic clk,
  input logic rst,
`ifdef AES_DEC_ABORT_EN
  input logic abort,
`endif
  aes_dec_round_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  counter_reg;
  logic [DATA_W-1:0] dec_in_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic              err_reg;
  logic [4:0]        nr_reg;
  logic [1:0]        sel_reg;

  logic              key_ok;
  logic              abort_hit;
  logic [4:0]        nr_next;
  logic [CNT_W-1:0]  last_cnt;
  logic [DATA_W-1:0] sel_out;

`ifdef AES_DEC_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign key_ok   = (bus.key_len != 2'd3);
  assign last_cnt = CNT_W'({nr_reg, 1'b0}) - CNT_W'(1);

  always_comb begin
    nr_next = 5'd14;
    case (bus.key_len)
      2'd0:    nr_next = 5'd10;
      2'd1:    nr_next = 5'd12;
      default: nr_next = 5'd14;
    endcase
  end

  always_comb begin
    sel_out = bus.dec_out_256;
    case (sel_reg)
      2'd0:    sel_out = bus.dec_out_128;
      2'd1:    sel_out = bus.dec_out_192;
      default: sel_out = bus.dec_out_256;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      counter_reg   <= '0;
      dec_in_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      nr_reg        <= 5'd10;
      sel_reg       <= 2'd0;
    end else begin
      err_reg <= 1'b0;
      // Abort wins over everything, including a request offered in IDLE.
      if (abort_hit) begin
        state_reg     <= ST_IDLE;
        counter_reg   <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (bus.in_valid) begin
              if (key_ok) begin
                dec_in_reg  <= bus.in_data;
                sel_reg     <= bus.key_len;
                nr_reg      <= nr_next;
                counter_reg <= CNT_W'(nr_next);
                state_reg   <= ST_ROUND;
              end else begin
                err_reg <= 1'b1;
              end
            end
          end
          ST_ROUND: begin
            // Counter runs Nr .. 2*Nr-1; the last value always leaves ROUND.
            if (counter_reg >= last_cnt) begin
              out_data_reg  <= sel_out;
              out_valid_reg <= 1'b1;
              counter_reg   <= '0;
              state_reg     <= ST_HOLD;
            end else begin
              counter_reg <= counter_reg + CNT_W'(1);
            end
          end
          ST_HOLD: begin
            if (bus.out_ready) begin
              out_valid_reg <= 1'b0;
              state_reg     <= ST_IDLE;
            end
          end
          default: begin
            state_reg     <= ST_IDLE;
            counter_reg   <= '0;
            out_valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = (state_reg == ST_IDLE);
  assign bus.busy        = (state_reg == ST_ROUND);
  assign bus.dec_in      = dec_in_reg;
  assign bus.dec_counter = counter_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_data    = out_data_reg;
  assign bus.err         = err_reg;

endmodule

// File: tb/tb_aes_dec_round_sequencer.sv
// Self-checking bench for aes_dec_round_sequencer: vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_aes_dec_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_dec_round_sequencer_if bus ();

`ifdef AES_DEC_ABORT_EN
  logic abort = 1'b0;
`endif

  aes_dec_round_sequencer dut (
    .clk(clk),
    .rst(rst),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .bus(bus)
  );

  // Datapath stand-ins: each shows its plaintext only on its final round count.
  logic [127:0] pt [3];
  assign bus.dec_out_128 = (bus.dec_counter == 6'd19) ? pt[0] : ~pt[0];
  assign bus.dec_out_192 = (bus.dec_counter == 6'd23) ? pt[1] : ~pt[1];
  assign bus.dec_out_256 = (bus.dec_counter == 6'd27) ? pt[2] : ~pt[2];

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0]   kl;
    logic [127:0] ct;
    logic [127:0] pt;
    int           hold;
    int           nr;
    logic         err;
  } vec_t;

  vec_t vecs [6];

  localparam logic [127:0] PT_REF  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic refresh_pts();
    for (int i = 0; i < 3; i++) pt[i] = rand128();
  endtask

  // One request from IDLE to completion; entered and left at a falling edge.
  task automatic do_txn(input logic [1:0] kl, input logic [127:0] ct, input int hold,
                        input int exp_nr, input logic exp_err, input logic [127:0] exp_pt);
    check("idle_in_ready", bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.key_len   = kl;
    bus.in_data   = ct;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = rand128();
    bus.key_len  = 2'($urandom);
    if (exp_err) begin
      check("err_pulse", bus.err, 1'b1);
      check("err_flags", {bus.busy, bus.in_ready, bus.out_valid}, 3'b010);
      check("err_cnt", bus.dec_counter, 0);
      @(negedge clk);
      check("err_clear", bus.err, 1'b0);
      check("err_no_out", {bus.busy, bus.out_valid, bus.dec_counter}, 0);
    end else begin
      for (int k = 0; k < exp_nr; k++) begin
        check("round_cnt", bus.dec_counter, 128'(exp_nr + k));
        check("round_flags", {bus.busy, bus.in_ready, bus.out_valid, bus.err}, 4'b1000);
        check("round_dec_in", bus.dec_in, ct);
        @(negedge clk);
      end
      check("out_valid", bus.out_valid, 1'b1);
      check("out_data", bus.out_data, exp_pt);
      check("hold_flags", {bus.busy, bus.in_ready, bus.dec_counter}, 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("bp_valid", {bus.out_valid, bus.in_ready}, 2'b10);
        check("bp_data", bus.out_data, exp_pt);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'($urandom);
      check("done_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
      check("done_dec_in", bus.dec_in, ct);
    end
    $display("txn key_len=%0d ct=%h hold=%0d nr=%0d err=%0d", kl, ct, hold, exp_nr, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key_len   = 2'd0;
    bus.out_ready = 1'b0;
    refresh_pts();

    vecs[0] = '{kl: 2'd0, ct: CT_128,    pt: PT_REF,    hold: 0, nr: 10, err: 1'b0};
    vecs[1] = '{kl: 2'd2, ct: CT_256,    pt: PT_REF,    hold: 0, nr: 14, err: 1'b0};
    vecs[2] = '{kl: 2'd1, ct: CT_192,    pt: PT_REF,    hold: 5, nr: 12, err: 1'b0};
    vecs[3] = '{kl: 2'd3, ct: rand128(), pt: '0,        hold: 0, nr: 0,  err: 1'b1};
    vecs[4] = '{kl: 2'd1, ct: rand128(), pt: rand128(), hold: 0, nr: 12, err: 1'b0};
    vecs[5] = '{kl: 2'd0, ct: rand128(), pt: rand128(), hold: 2, nr: 10, err: 1'b0};

    // Asynchronous reset state, observed before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_cnt", bus.dec_counter, 0);
    check("rst_dec_in", bus.dec_in, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_flags", {bus.out_valid, bus.err, bus.busy, bus.in_ready}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      refresh_pts();
      if (!vecs[i].err) pt[vecs[i].kl] = vecs[i].pt;
      do_txn(vecs[i].kl, vecs[i].ct, vecs[i].hold, vecs[i].nr, vecs[i].err, vecs[i].pt);
    end

    // Backpressure with a request already waiting, then async reset mid-ROUND.
    refresh_pts();
    pt[1] = PT_REF;
    bus.in_valid  = 1'b1;
    bus.key_len   = 2'd1;
    bus.in_data   = CT_192;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.key_len = 2'd0;
    bus.in_data = CT_128;
    for (int k = 0; k < 12; k++) begin
      check("bp_round_cnt", bus.dec_counter, 128'(12 + k));
      check("bp_round_dec_in", bus.dec_in, CT_192);
      @(negedge clk);
    end
    check("bp_out", {bus.out_valid, bus.out_data}, {1'b1, PT_REF});
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("bp_hold_out", {bus.out_valid, bus.out_data}, {1'b1, PT_REF});
      check("bp_hold_block", {bus.in_ready, bus.dec_counter}, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_after_hs", {bus.out_valid, bus.in_ready, bus.dec_counter}, 8'b0100_0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_next_accept", bus.dec_counter, 10);
    check("bp_next_dec_in", bus.dec_in, CT_128);
    repeat (5) @(negedge clk);
    check("pre_rst_cnt", bus.dec_counter, 15);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cnt", bus.dec_counter, 0);
    check("mid_rst_flags", {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
    check("mid_rst_dec_in", bus.dec_in, 0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_idle", {bus.out_valid, bus.dec_counter}, 0);
    refresh_pts();
    pt[0] = PT_REF;
    do_txn(2'd0, CT_128, 0, 10, 1'b0, PT_REF);

`ifdef AES_DEC_ABORT_EN
    // Abort mid-ROUND, then abort competing with a request in IDLE.
    begin
      logic seen_valid;
      seen_valid = 1'b0;
      bus.in_valid = 1'b1;
      bus.key_len  = 2'd0;
      bus.in_data  = CT_128;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_pre_cnt", bus.dec_counter, 12);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", {bus.in_ready, bus.busy, bus.out_valid, bus.dec_counter}, 9'b1_0000_0000);
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (bus.out_valid) seen_valid = 1'b1;
      end
      check("abort_no_out", seen_valid, 1'b0);
      abort        = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_blocks_accept", {bus.in_ready, bus.dec_counter}, 7'b100_0000);
      $display("txn abort sequence done");
    end
`endif

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 30; n++) begin
      logic [1:0]   kl;
      logic [127:0] ct;
      int           gap;
      kl = 2'($urandom_range(0, 3));
      ct = rand128();
      gap = $urandom_range(0, 2);
      refresh_pts();
      for (int g = 0; g < gap; g++) begin
        bus.in_data = rand128();
        @(negedge clk);
        check("gap_idle", {bus.in_ready, bus.dec_counter}, 7'b100_0000);
      end
      if (kl == 2'd3)
        do_txn(kl, ct, 0, 0, 1'b1, '0);
      else
        do_txn(kl, ct, $urandom_range(0, 3), 10 + 2 * int'(kl), 1'b0, pt[kl]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_sequencer.md
Name: aes_dec_round_sequencer

Overview:
- Control block for the iterative AES decryption round datapath.
- Accepts one ciphertext block per request over a valid/ready handshake and selects the key length (128/192/256).
- Drives the shared 6-bit round counter and holds the ciphertext stable for the round datapaths.
- Picks the result from the one of three datapath instances (Nr = 10/12/14) that matches the key length, then returns the plaintext over a valid/ready output handshake.

Parameters:
- DATA_W, 128, block width; fixed at 128, kept for readability.
- CNT_W, 6, round counter width; must match the datapath counter port.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  sequencer can accept a request
- in_data  input  128  ciphertext block
- key_len  input  2  0=AES-128 (Nr 10), 1=AES-192 (Nr 12), 2=AES-256 (Nr 14), 3=illegal
- dec_in  output  128  ciphertext held for the datapaths
- dec_counter  output  6  round counter to all datapath instances
- dec_out_128  input  128  output of the Nr=10 instance
- dec_out_192  input  128  output of the Nr=12 instance
- dec_out_256  input  128  output of the Nr=14 instance
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer accepts the plaintext
- out_data  output  128  plaintext block
- busy  output  1  high while in the ROUND state
- err  output  1  one-cycle pulse when a request with key_len=3 is consumed

Behaviour:
- Reset (async, active-high): state=IDLE, dec_counter=0, dec_in=0, out_data=0, out_valid=0, err=0, busy=0, nr_reg=10, sel_reg=0.
- IDLE:
  - in_ready=1, dec_counter=0.
  - On a clock edge with in_valid=1 and key_len in 0..2:
    - dec_in <= in_data.
    - sel_reg <= key_len; nr_reg <= 10/12/14 according to key_len.
    - dec_counter <= nr_reg value (10, 12 or 14).
    - Next state ROUND.
  - On a clock edge with in_valid=1 and key_len=3: request consumed, err=1 for the next cycle only, stay in IDLE, no output produced.
- ROUND:
  - in_ready=0, busy=1.
  - dec_counter increments by 1 each cycle.
  - In the cycle where dec_counter == 2*nr_reg-1:
    - out_data <= selected dec_out_* (mux on sel_reg).
    - out_valid <= 1, dec_counter <= 0, next state HOLD.
  - dec_counter therefore spans Nr .. 2*Nr-1, which is Nr cycles.
- HOLD:
  - out_valid=1; out_data and dec_in stay stable.
  - On an edge with out_ready=1: out_valid <= 0, next state IDLE.
  - out_ready is ignored in every other state.
- Latency: from the accepting edge to out_valid high = Nr clock edges (10/12/14).
- Throughput: at most one block per Nr+2 cycles when out_ready is held at 1.
- Stability rules:
  - dec_in is constant for the whole ROUND state.
  - in_data changes while not accepted have no effect.
  - key_len is sampled only at the accepting edge.
- No combinational path exists from in_valid to in_ready or from out_ready to out_valid. in_ready is a decode of the state register only.
- Reset asserted mid-operation: all outputs return to reset values immediately, with no clock needed. The in-flight block is lost and no out_valid is issued.
- dec_counter never exceeds 27 and never wraps. Reaching 2*nr_reg-1 always exits ROUND.

Optional Feature:
- Macro: AES_DEC_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 at a clock edge in ROUND or HOLD forces state=IDLE, dec_counter=0, out_valid=0; out_data keeps its last value.
  - abort=1 in IDLE has priority over request acceptance: in_valid is not consumed on that edge.
- When undefined: the abort port does not exist and the state machine behaves exactly as described above.

Test Plan:
- Reset then AES-128: key_len=0, in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1, datapaths keyed with 000102…0f. Required: dec_counter sequence 10,11,…,19; out_valid 10 edges after acceptance; out_data=00112233445566778899aabbccddeeff; then IDLE with in_ready=1.
- AES-256: key_len=2, in_data=8ea2b7ca516745bfeafc49904b496089, key 000102…1f. Required: dec_counter 14..27; out_data=00112233445566778899aabbccddeeff; 14-cycle latency.
- Backpressure: AES-192 (dd a97ca4864cdfe06eaf70a0ec0d7191 ciphertext, key 000102…17) with out_ready=0 for 5 cycles after out_valid. Required: out_data and out_valid held; in_ready=0; a new in_valid is not accepted until the cycle after the out_ready handshake.
- Illegal key: key_len=3, in_valid=1 for one cycle. Required: err high for exactly one cycle; busy stays 0; out_valid stays 0; dec_counter stays 0.
- Async reset mid-ROUND: assert rst between clock edges at dec_counter=15 (AES-128). Required: dec_counter=0, busy=0, out_valid=0 immediately. A following request completes normally.
- With AES_DEC_ABORT_EN: pulse abort at dec_counter=12 (AES-128). Required: IDLE on the next edge, out_valid never asserted, in_ready=1.
